// File: rtl/alu_req_ctrl_pkg.sv
// Shared RISC-V execute-stage definitions.
// Contents: datapath width, ALU opcode enum, requester FSM state enum and
// the default response timeout for alu_req_ctrl.
package _pkg_riscv_defines;

    localparam int unsigned DATA_WIDTH              = 32;
    localparam int unsigned ALU_REQ_TIMEOUT_DEFAULT = 64;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } alu_req_state_t;

endpackage

// File: rtl/alu_if.sv
// Request/response link between the execute-stage requester and the ALU.
// master: drives operand1/operand2/alu_op/req_valid; samples result/resp_valid
//         and the ALU-owned resp_ready.
// slave : the ALU side, mirror image of master.
interface alu_if;
    import _pkg_riscv_defines::*;

    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    alu_op_t               alu_op;
    logic                  req_valid;
    logic [DATA_WIDTH-1:0] result;
    logic                  resp_valid;
    logic                  resp_ready;

    modport master (
        output operand1, operand2, alu_op, req_valid,
        input  result, resp_valid, resp_ready
    );

    modport slave (
        input  operand1, operand2, alu_op, req_valid,
        output result, resp_valid, resp_ready
    );

endinterface

// File: rtl/alu_req_ctrl.sv
// Execute-stage requester for alu_if: takes one decoded op via valid/ready,
// presents it to the ALU, waits for the one-cycle response pulse and holds
// the captured result for writeback. One op in flight; flush abandons the
// current op; a stalled ALU raises a sticky timeout_err.
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   in_valid/in_ready/in_op/in_src1/in_src2/in_rd   decode-side handshake
//   alu_if (master)                    request/response link to the ALU
//   flush                              abandon the current op
//   out_valid/out_ready/out_result/out_rd           writeback handshake
//   busy                               any state other than IDLE
//   timeout_err                        sticky response timeout flag
module alu_req_ctrl
    import _pkg_riscv_defines::*;
#(
    parameter int unsigned DATA_WIDTH     = _pkg_riscv_defines::DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = ALU_REQ_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_op_t               in_op,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [4:0]            in_rd,
    alu_if.master                 alu_if,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_rd,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    alu_req_state_t        state_q,       state_d;
    alu_op_t               op_q,          op_d;
    logic [DATA_WIDTH-1:0] src1_q,        src1_d;
    logic [DATA_WIDTH-1:0] src2_q,        src2_d;
    logic [4:0]            rd_q,          rd_d;
    logic [DATA_WIDTH-1:0] result_q,      result_d;
    logic [4:0]            out_rd_q,      out_rd_d;
    logic                  req_valid_q,   req_valid_d;
    logic                  out_valid_q,   out_valid_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [TW-1:0]         timer_q,       timer_d;

    logic accept;
    logic req_fire;

    assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign req_fire = req_valid_q && alu_if.resp_ready;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        rd_d          = rd_q;
        result_d      = result_q;
        out_rd_d      = out_rd_q;
        req_valid_d   = req_valid_q;
        out_valid_d   = out_valid_q;
        timeout_err_d = timeout_err_q;
        timer_d       = timer_q;

        // accept is only possible in IDLE or DONE, never while an op is live
        if (accept) begin
            op_d   = in_op;
            src1_d = in_src1;
            src2_d = in_src2;
            rd_d   = in_rd;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    // the ALU took the op this cycle, so its pulse is still owed
                    req_valid_d = 1'b0;
                    state_d     = req_fire ? DRAIN : IDLE;
                end else if (req_fire) begin
                    req_valid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    // a pulse arriving together with flush is discarded here;
                    // draining for it afterwards would never terminate
                    state_d = alu_if.resp_valid ? IDLE : DRAIN;
                end else if (alu_if.resp_valid) begin
                    result_d    = alu_if.result;
                    out_rd_d    = rd_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = DRAIN;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                if (flush) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        req_valid_d = 1'b1;
                        state_d     = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // an owed pulse must be consumed even under flush
                if (alu_if.resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= ALU_ADD;
            src1_q        <= '0;
            src2_q        <= '0;
            rd_q          <= '0;
            result_q      <= '0;
            out_rd_q      <= '0;
            req_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            rd_q          <= rd_d;
            result_q      <= result_d;
            out_rd_q      <= out_rd_d;
            req_valid_q   <= req_valid_d;
            out_valid_q   <= out_valid_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign alu_if.operand1  = src1_q;
    assign alu_if.operand2  = src2_q;
    assign alu_if.alu_op    = op_q;
    assign alu_if.req_valid = req_valid_q;

    assign out_valid   = out_valid_q;
    assign out_result  = result_q;
    assign out_rd      = out_rd_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_alu_req_ctrl.sv
`timescale 1ns/1ps
module tb_alu_req_ctrl;
    import _pkg_riscv_defines::*;

    localparam int unsigned DELAY = 10;
    localparam int unsigned TMO   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_op_t     in_op = ALU_ADD;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;
    logic        timeout_err;

    alu_if u_bus ();

    alu_req_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
        .alu_if(u_bus), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    // ALU stub: answers DELAY+1 cycles after accepting, one spurious pulse after reset,
    // busy (resp_ready low) while an answer is pending, never answers when alu_dead.
    logic        ready_en = 1'b1;
    logic        alu_dead = 1'b0;
    logic        pend;
    int unsigned pend_cnt;
    logic [31:0] pend_res;
    int unsigned pulses = 0;

    assign u_bus.resp_ready = ready_en && !pend;
    assign u_bus.resp_valid = rst_n && pend && !alu_dead && (pend_cnt == 0);
    assign u_bus.result     = pend_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b1;
            pend_cnt <= DELAY;
            pend_res <= 32'hDEAD_BEEF;
        end else if (u_bus.req_valid && u_bus.resp_ready) begin
            pend     <= 1'b1;
            pend_cnt <= DELAY;
            pend_res <= alu_ref(u_bus.alu_op, u_bus.operand1, u_bus.operand2);
        end else if (pend) begin
            if (pend_cnt == 0) begin
                if (!alu_dead) pend <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (rst_n && u_bus.resp_valid === 1'b1) pulses++;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait budget expired at t=%0t", name, $time);
    endtask

    // Behavioural model: what the requester owes at each moment.
    logic        m_req, m_wait, m_drain, m_hold, m_err;
    int unsigned m_wcnt;
    alu_op_t     m_op;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_rd, m_ord;

    initial begin : cmp
        logic exp_busy, exp_inr, acc, rr, rv;
        logic n_req, n_wait, n_drain, n_hold, n_err;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_req = 0; m_wait = 0; m_drain = 0; m_hold = 0; m_err = 0; m_wcnt = 0;
                m_op = ALU_ADD; m_a = '0; m_b = '0; m_rd = '0; m_res = '0; m_ord = '0;
            end
            exp_busy = m_req || m_wait || m_drain || m_hold;
            exp_inr  = !flush && (!exp_busy || (m_hold && out_ready));
            check("req_valid", u_bus.req_valid, m_req);
            check("out_valid", out_valid, m_hold);
            check("busy", busy, exp_busy);
            check("timeout_err", timeout_err, m_err);
            check("in_ready", in_ready, exp_inr);
            if (m_req) begin
                check("operand1", u_bus.operand1, m_a);
                check("operand2", u_bus.operand2, m_b);
                check("alu_op", u_bus.alu_op, m_op);
            end
            if (m_hold) begin
                check("out_result", out_result, m_res);
                check("out_rd", out_rd, m_ord);
            end
            if (rst_n) begin
                acc = in_valid && exp_inr;
                rr  = u_bus.resp_ready;
                rv  = u_bus.resp_valid;
                n_req = m_req; n_wait = m_wait; n_drain = m_drain; n_hold = m_hold; n_err = m_err;
                if (m_drain && rv) n_drain = 0;
                if (flush) begin
                    n_hold = 0;
                    if (m_req) begin n_req = 0; if (rr) n_drain = 1; end
                    if (m_wait) begin n_wait = 0; if (!rv) n_drain = 1; end
                end else begin
                    if (m_req && rr) begin n_req = 0; n_wait = 1; m_wcnt = 0; end
                    if (m_wait) begin
                        if (rv) begin
                            n_wait = 0; n_hold = 1;
                            m_res = alu_ref(m_op, m_a, m_b); m_ord = m_rd;
                        end else if (m_wcnt == TMO - 1) begin
                            n_wait = 0; n_err = 1; n_drain = 1;
                        end else begin
                            m_wcnt++;
                        end
                    end
                    if (m_hold && out_ready) n_hold = 0;
                    if (acc) begin
                        n_req = 1;
                        m_op = in_op; m_a = in_src1; m_b = in_src2; m_rd = in_rd;
                    end
                end
                m_req = n_req; m_wait = n_wait; m_drain = n_drain; m_hold = n_hold; m_err = n_err;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 0; in_valid = 0; flush = 0; out_ready = 1; ready_en = 1; alu_dead = 0;
        #1;
        check("rst_req_valid", u_bus.req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic wait_out(input string name, input int unsigned budget);
        int unsigned n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) timeout_fail(name);
    endtask

    task automatic drive_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic got;
        int unsigned delivered = 0;

        // idle after reset: spurious ALU pulse must be ignored
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_out_valid", out_valid, 0);
            check("idle_busy", busy, 0);
        end
        check("spurious_pulse_seen", pulses, 1);

        // ADD 5+7 rd=3: req_valid cycle 1 only, out_valid cycle 13
        tick(); drive_op(ALU_ADD, 32'd5, 32'd7, 5'd3);
        @(negedge clk); check("add_in_ready", in_ready, 1);
        tick(); in_valid = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check("add_req_valid", u_bus.req_valid, (k == 1) ? 1 : 0);
            check("add_out_valid", out_valid, (k == 13) ? 1 : 0);
            if (k == 13) begin
                check("add_result", out_result, 32'd12);
                check("add_rd", out_rd, 32'd3);
            end
        end

        // op right after reset with ALU not ready: request held, operands stable
        do_reset();
        ready_en = 0;
        drive_op(ALU_ADD, 32'h1111_1111, 32'h2222_2222, 5'd7);
        tick(); in_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("hold_req_valid", u_bus.req_valid, 1);
            check("hold_operand1", u_bus.operand1, 32'h1111_1111);
            check("hold_operand2", u_bus.operand2, 32'h2222_2222);
        end
        tick(); ready_en = 1;
        wait_out("hold_wait_out", 40);
        check("hold_result", out_result, 32'h3333_3333);
        check("hold_rd", out_rd, 32'd7);

        // SUB 3-5 held 5 cycles with out_ready=0, then back-to-back SRA
        tick(); out_ready = 0; drive_op(ALU_SUB, 32'd3, 32'd5, 5'd9);
        tick(); in_valid = 0;
        wait_out("sub_wait_out", 40);
        for (int i = 0; i < 5; i++) begin
            check("sub_out_valid", out_valid, 1);
            check("sub_result", out_result, 32'hFFFF_FFFE);
            check("sub_rd", out_rd, 32'd9);
            check("sub_in_ready", in_ready, 0);
            tick(); drive_op(ALU_SRA, 32'h8000_0000, 32'd4, 5'd12);
            if (i == 4) out_ready = 1;
            @(negedge clk);
        end
        check("b2b_in_ready", in_ready, 1);
        tick(); in_valid = 0;
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_req_valid", u_bus.req_valid, 1);
        check("b2b_out_valid", out_valid, 0);
        tick();
        wait_out("sra_wait_out", 40);
        check("sra_result", out_result, 32'hF800_0000);
        check("sra_rd", out_rd, 32'd12);

        // flush in WAIT, then a new op: stale result never shown
        tick(); drive_op(ALU_XOR, 32'h0000_1234, 32'h0000_FFFF, 5'd4);
        tick(); in_valid = 0;
        repeat (4) @(negedge clk);
        tick(); flush = 1; drive_op(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 5'd5);
        @(negedge clk); check("flush_in_ready", in_ready, 0);
        tick(); flush = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            check("flush_no_stale", out_valid, 0);
            if (in_ready) got = 1;
        end
        if (!got) timeout_fail("flush_accept");
        tick(); in_valid = 0;
        wait_out("flush_wait_out", 40);
        check("flush_new_result", out_result, 32'h0000_00FF);
        check("flush_new_rd", out_rd, 32'd5);

        // ALU never answers: timeout_err at WAIT cycle 64, sticky until reset
        tick(); alu_dead = 1; drive_op(ALU_ADD, 32'd1, 32'd1, 5'd1);
        @(negedge clk); check("tmo_in_ready", in_ready, 1);
        tick(); in_valid = 0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            check("tmo_edge", timeout_err, (k >= 66) ? 1 : 0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("tmo_sticky", timeout_err, 1);
            check("tmo_busy", busy, 1);
        end
        do_reset();
        @(negedge clk);
        check("tmo_cleared", timeout_err, 0);

        // randomized traffic, including one reset mid-run
        repeat (20) tick();
        for (int i = 0; i < 600; i++) begin
            tick();
            if (i == 300) begin
                do_reset();
                repeat (12) tick();
            end
            in_valid  = ($urandom_range(0, 1) == 1);
            in_op     = alu_op_t'($urandom_range(0, 7));
            in_src1   = $urandom;
            in_src2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            in_rd     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 9) < 7);
            ready_en  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0) && (u_bus.resp_valid !== 1'b1);
            @(negedge clk);
            if (out_valid && out_ready && !flush) delivered++;
        end
        tick(); in_valid = 0; flush = 0;
        check("rand_results_seen", (delivered > 10) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
